multi_port_memory_arbiter: RTL
==============================

Name: multi_port_memory_arbiter

Overview:
Parametrised N-port successor to the core's two-source memory arbiter. It arbitrates between NUM_PORTS requesters (I-cache, D-cache, prefetcher, DMA, ...) for the single off-core memory interface. Arbitration is fixed-priority or round-robin, selected by parameter. The grant is locked for a whole burst and released on i_MEM_Last. All addresses are word addresses.

Parameters:
DATA_WIDTH, 32, data bus width per port and on the memory side
ADDRESS_WIDTH, 21, word-address width
NUM_PORTS, 4, number of requesters (2..8); port p is at slice [p*W +: W] of each packed bus
ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority with port 0 highest
IDX_WIDTH, 3, width of the last-served index register; must be >= clog2(NUM_PORTS)

Ports:
i_Clk  in  1  clock
i_Reset_n  in  1  asynchronous active-low reset
i_Port_Valid  in  NUM_PORTS  per-port request valid
i_Port_Read_Write_n  in  NUM_PORTS  per-port 1 = read, 0 = write
i_Port_Address  in  NUM_PORTS*ADDRESS_WIDTH  per-port request address
i_Port_Data  in  NUM_PORTS*DATA_WIDTH  per-port write data
o_Port_Valid  out  NUM_PORTS  read beat valid, granted port only
o_Port_Data_Read  out  NUM_PORTS  write beat consumed, granted port only
o_Port_Last  out  NUM_PORTS  last beat of burst, granted port only
o_Port_Data  out  DATA_WIDTH  i_MEM_Data broadcast to all ports
o_Grant  out  NUM_PORTS  one-hot current grant; 0 when idle
o_Busy  out  1  high while a grant is active
o_MEM_Valid  out  1  memory request valid
o_MEM_Address  out  ADDRESS_WIDTH  granted port's address
o_MEM_Read_Write_n  out  1  granted port's direction
o_MEM_Data  out  DATA_WIDTH  granted port's write data
i_MEM_Data_Read  in  1  memory consumed a write beat
i_MEM_Data  in  DATA_WIDTH  read data from memory
i_MEM_Valid  in  1  read beat valid
i_MEM_Last  in  1  final beat of the current transaction

Behaviour:
- Registers: State (READY, SERVICING), Grant_Idx, Last_Idx. Reset values: State = READY, Grant_Idx = 0, Last_Idx = NUM_PORTS-1, so port 0 wins first under round-robin.
- All outputs are combinational from the registers and inputs. While i_Reset_n = 0, requests are ignored and every output is 0.
- Output defaults: every output 0, including o_MEM_Address and o_MEM_Data. o_MEM_Read_Write_n defaults to 1 (READ). No X is driven.
- Winner selection in READY:
  - Fixed priority: lowest-index valid port wins.
  - Round-robin: search starts at (Last_Idx+1) mod NUM_PORTS and wraps; the first valid port wins.
- Zero-latency grant. When a request is valid in READY, the winner is connected in the same cycle: o_Grant, o_Busy, o_MEM_Valid = 1 and the winner's address, direction and data are routed.
- READY -> SERVICING when any port is valid and i_MEM_Last = 0. Grant_Idx <= winner.
- READY with a valid request and i_MEM_Last = 1 (single-beat transaction): stay in READY. Last_Idx <= winner.
- SERVICING:
  - The grant is locked to Grant_Idx and o_MEM_Valid is held 1, even if the port drops its valid. Other requests are ignored.
  - Memory handshakes are routed only to the granted port: i_MEM_Valid -> o_Port_Valid[g], i_MEM_Data_Read -> o_Port_Data_Read[g], i_MEM_Last -> o_Port_Last[g].
  - On i_MEM_Last: go to READY and set Last_Idx <= Grant_Idx. No dead cycle is required; the next winner is selected in the first READY cycle.
- i_MEM_Valid, i_MEM_Data_Read and i_MEM_Last in READY with no request: ignored, no port outputs asserted.
- Reset asserted mid-burst: immediate return to READY. The burst is abandoned and all outputs drop asynchronously.
- Fixed-priority mode: Last_Idx is still updated but does not affect winner selection.
- o_Grant is always one-hot or zero.

Test Plan:
- Reset, then ports 0 and 2 request, ROUND_ROBIN=1, 4-beat reads -> port 0 served first with o_Grant=0001; after its i_MEM_Last, port 2 granted (0100) with no idle cycle.
- All 4 ports request continuously, round-robin, 2-beat bursts -> grant order 0,1,2,3,0; each port's o_Port_Last is pulsed exactly once per turn.
- ROUND_ROBIN=0, ports 1 and 3 request continuously -> port 1 is granted on every arbitration; port 3 is never granted until port 1 drops its valid.
- Port 1 write, address 0x00ABC, data 0xDEADBEEF, 2 beats with i_MEM_Data_Read pulses -> o_MEM_Read_Write_n=0, o_MEM_Address=0x00ABC; o_Port_Data_Read[1] mirrors each pulse; other ports' handshake outputs stay 0.
- Single-beat transaction (request with i_MEM_Last=1 in the same cycle) -> State stays READY, Last_Idx advances; the next cycle's winner is the following port.
- i_Reset_n pulsed low during the 2nd beat of a 4-beat port 2 burst -> all outputs 0 at once; after release, arbitration restarts from port 0.

Source files
------------

// File: rtl/multi_port_memory_arbiter_if.sv
// Requester and memory-side signals of the N-port memory arbiter.
// slave = arbiter view, master = requesters plus memory model.
interface multi_port_memory_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 21,
    parameter int NUM_PORTS     = 4
);
    logic [NUM_PORTS-1:0]               i_Port_Valid;
    logic [NUM_PORTS-1:0]               i_Port_Read_Write_n;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] i_Port_Address;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    i_Port_Data;
    logic [NUM_PORTS-1:0]               o_Port_Valid;
    logic [NUM_PORTS-1:0]               o_Port_Data_Read;
    logic [NUM_PORTS-1:0]               o_Port_Last;
    logic [DATA_WIDTH-1:0]              o_Port_Data;
    logic [NUM_PORTS-1:0]               o_Grant;
    logic                               o_Busy;
    logic                               o_MEM_Valid;
    logic [ADDRESS_WIDTH-1:0]           o_MEM_Address;
    logic                               o_MEM_Read_Write_n;
    logic [DATA_WIDTH-1:0]              o_MEM_Data;
    logic                               i_MEM_Data_Read;
    logic [DATA_WIDTH-1:0]              i_MEM_Data;
    logic                               i_MEM_Valid;
    logic                               i_MEM_Last;

    modport slave (
        input  i_Port_Valid, i_Port_Read_Write_n,
        input  i_Port_Address, i_Port_Data,
        input  i_MEM_Data_Read, i_MEM_Data,
        input  i_MEM_Valid, i_MEM_Last,
        output o_Port_Valid, o_Port_Data_Read,
        output o_Port_Last, o_Port_Data,
        output o_Grant, o_Busy, o_MEM_Valid,
        output o_MEM_Address, o_MEM_Read_Write_n,
        output o_MEM_Data
    );

    modport master (
        output i_Port_Valid, i_Port_Read_Write_n,
        output i_Port_Address, i_Port_Data,
        output i_MEM_Data_Read, i_MEM_Data,
        output i_MEM_Valid, i_MEM_Last,
        input  o_Port_Valid, o_Port_Data_Read,
        input  o_Port_Last, o_Port_Data,
        input  o_Grant, o_Busy, o_MEM_Valid,
        input  o_MEM_Address, o_MEM_Read_Write_n,
        input  o_MEM_Data
    );
endinterface

// File: rtl/multi_port_memory_arbiter.sv
// N-port arbiter for the single off-core memory interface.
// Fixed-priority or round-robin; grant locked for a whole burst.
module multi_port_memory_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 21,
    parameter int NUM_PORTS     = 4,
    parameter int ROUND_ROBIN   = 1,
    parameter int IDX_WIDTH     = 3
) (
    input  logic i_Clk,
    input  logic i_Reset_n,
    multi_port_memory_arbiter_if.slave bus
);
    typedef enum logic {READY, SERVICING} state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [IDX_WIDTH-1:0] last_idx;
    logic [IDX_WIDTH-1:0] winner;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic                 any_valid;
    logic                 active;

    assign any_valid = |bus.i_Port_Valid;

    // Scan downwards so the port closest to the start point wins.
    always_comb begin : pick
        int start;
        int p;
        winner = '0;
        start  = 0;
        p      = 0;
        if (ROUND_ROBIN != 0)
            start = (int'(last_idx) + 1) % NUM_PORTS;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            p = (start + i) % NUM_PORTS;
            if (bus.i_Port_Valid[p])
                winner = IDX_WIDTH'(p);
        end
    end

    assign sel_idx = (state == SERVICING) ? grant_idx : winner;
    assign active  = i_Reset_n &&
                     ((state == SERVICING) || any_valid);

    always_comb begin
        bus.o_Grant            = '0;
        bus.o_Port_Valid       = '0;
        bus.o_Port_Data_Read   = '0;
        bus.o_Port_Last        = '0;
        bus.o_MEM_Address      = '0;
        bus.o_MEM_Data         = '0;
        bus.o_MEM_Read_Write_n = i_Reset_n;
        bus.o_Port_Data        = i_Reset_n ? bus.i_MEM_Data : '0;
        bus.o_Busy             = active;
        bus.o_MEM_Valid        = active;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (active && (sel_idx == IDX_WIDTH'(p))) begin
                bus.o_Grant[p]          = 1'b1;
                bus.o_Port_Valid[p]     = bus.i_MEM_Valid;
                bus.o_Port_Data_Read[p] = bus.i_MEM_Data_Read;
                bus.o_Port_Last[p]      = bus.i_MEM_Last;
                bus.o_MEM_Address       =
                    bus.i_Port_Address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                bus.o_MEM_Read_Write_n  = bus.i_Port_Read_Write_n[p];
                bus.o_MEM_Data          =
                    bus.i_Port_Data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A request seen together with i_MEM_Last is a complete single beat.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state     <= READY;
            grant_idx <= '0;
            last_idx  <= IDX_WIDTH'(NUM_PORTS - 1);
        end else begin
            unique case (state)
                READY: begin
                    if (any_valid) begin
                        if (bus.i_MEM_Last) begin
                            last_idx <= winner;
                        end else begin
                            state     <= SERVICING;
                            grant_idx <= winner;
                        end
                    end
                end
                SERVICING: begin
                    if (bus.i_MEM_Last) begin
                        state    <= READY;
                        last_idx <= grant_idx;
                    end
                end
                default: state <= READY;
            endcase
        end
    end
endmodule
